wave_nco: RTL and testbench

WAVE_NCO -- requirements
Module: wave_nco

---
 rtl/wave_nco_if.sv | 24 ++
 rtl/wave_nco.sv | 121 ++++++++++++
 tb/tb_wave_nco.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wave_nco_if.sv
// Configuration channel for the wave NCO.
// Valid/ready handshake carrying frequency, phase, mode, duty and sync.
interface wave_nco_if #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [ACC_W-1:0] cfg_freq;
    logic [ACC_W-1:0] cfg_phase;
    logic [1:0]       cfg_mode;
    logic [OUT_W-1:0] cfg_duty;
    logic             cfg_sync;

    modport master (
        output cfg_valid, cfg_freq, cfg_phase, cfg_mode, cfg_duty, cfg_sync,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_freq, cfg_phase, cfg_mode, cfg_duty, cfg_sync,
        output cfg_ready
    );
endinterface

// File: rtl/wave_nco.sv
// Phase-accumulator NCO with saw, triangle, pulse and inverted saw outputs.
// Config updates either apply at once or wait for the next accumulator wrap.
module wave_nco #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    wave_nco_if.slave               cfg,
    output logic signed [OUT_W-1:0] value,
    output logic                    wrap
);
    typedef enum logic {IDLE, PENDING} state_t;

    localparam logic [OUT_W-1:0] M    = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] PMAX = ~M;
    localparam logic [OUT_W-1:0] NMAX = M | {{(OUT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] freq_q, phase_q;
    logic [1:0]       mode_q;
    logic [OUT_W-1:0] duty_q;
    logic [ACC_W-1:0] sh_freq_q, sh_phase_q;
    logic [1:0]       sh_mode_q;
    logic [OUT_W-1:0] sh_duty_q;
    logic [OUT_W-1:0] value_q, value_d;
    logic             wrap_q;

    logic [ACC_W:0]   sum;
    logic             carry;
    logic             accept;
    logic [OUT_W-1:0] t;
    logic [OUT_W-1:0] t2;
    logic [OUT_W-1:0] tri_r;

    assign cfg.cfg_ready = (state_q == IDLE) && !rst;
    assign accept = cfg.cfg_valid && cfg.cfg_ready;

    assign sum   = {1'b0, acc_q} + {1'b0, freq_q};
    assign carry = en && sum[ACC_W];

    assign t     = OUT_W'((acc_q + phase_q) >> (ACC_W - OUT_W));
    assign t2    = {t[OUT_W-2:0], 1'b0};
    assign tri_r = t[OUT_W-1] ? ~t2 : t2;

    // Next accumulator: hard sync wins over the normal advance.
    always_comb begin
        acc_d = acc_q;
        if (accept && cfg.cfg_sync)
            acc_d = '0;
        else if (en)
            acc_d = sum[ACC_W-1:0];
    end

    // Waveform mapping from the current accumulator and active config.
    always_comb begin
        value_d = '0;
        unique case (mode_q)
            2'd0: value_d = t ^ M;
            2'd1: value_d = tri_r ^ M;
            2'd2: value_d = (t < duty_q) ? PMAX : NMAX;
            2'd3: value_d = ~(t ^ M);
            default: value_d = '0;
        endcase
    end

    // Accumulator, config handshake FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            freq_q     <= '0;
            phase_q    <= '0;
            mode_q     <= '0;
            duty_q     <= M;
            sh_freq_q  <= '0;
            sh_phase_q <= '0;
            sh_mode_q  <= '0;
            sh_duty_q  <= '0;
            value_q    <= '0;
            wrap_q     <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            value_q <= value_d;
            wrap_q  <= carry;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (cfg.cfg_sync || !en) begin
                            freq_q  <= cfg.cfg_freq;
                            phase_q <= cfg.cfg_phase;
                            mode_q  <= cfg.cfg_mode;
                            duty_q  <= cfg.cfg_duty;
                        end else begin
                            sh_freq_q  <= cfg.cfg_freq;
                            sh_phase_q <= cfg.cfg_phase;
                            sh_mode_q  <= cfg.cfg_mode;
                            sh_duty_q  <= cfg.cfg_duty;
                            state_q    <= PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (!en || carry) begin
                        freq_q  <= sh_freq_q;
                        phase_q <= sh_phase_q;
                        mode_q  <= sh_mode_q;
                        duty_q  <= sh_duty_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign value = value_q;
    assign wrap  = wrap_q;
endmodule

// File: tb/tb_wave_nco.sv
// Self-checking bench for wave_nco.
// Expected samples are queued as stimulus is driven, then popped after each edge.
module tb_wave_nco;
    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] value;
    logic        wrap;

    wave_nco_if #(.ACC_W(32), .OUT_W(16)) cif ();

    wave_nco #(.ACC_W(32), .OUT_W(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .cfg   (cif),
        .value (value),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] v;
        logic        w;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   errs   = 0;
    int   checks = 0;

    task automatic offer(input logic [31:0] f, input logic [31:0] ph,
                         input logic [1:0] m, input logic [15:0] d,
                         input logic s);
        cif.cfg_valid = 1'b1;
        cif.cfg_freq  = f;
        cif.cfg_phase = ph;
        cif.cfg_mode  = m;
        cif.cfg_duty  = d;
        cif.cfg_sync  = s;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en  = 1'b1;
        offer(32'h1234_5678, 32'h0, 2'd1, 16'h1, 1'b1);
        #1;
        checks++;
        if (cif.cfg_ready !== 1'b0) begin
            errs++;
            $display("FAIL reset_ready_low: got %b want 0", cif.cfg_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (value !== 16'h0000) begin
            errs++;
            $display("FAIL reset_value: got %h want 0000", value);
        end
        checks++;
        if (wrap !== 1'b0) begin
            errs++;
            $display("FAIL reset_wrap: got %b want 0", wrap);
        end
        rst = 1'b0;
        en  = 1'b0;
        cif.cfg_valid = 1'b0;
        cif.cfg_sync  = 1'b0;
        #1;
        checks++;
        if (cif.cfg_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_ready_high: got %b want 1", cif.cfg_ready);
        end
    endtask

    task automatic test_saw;
        offer(32'h1000_0000, 32'h0, 2'd0, 16'h8000, 1'b0);
        q.push_back('{v: 16'h8000, w: 1'b0});
        @(posedge clk); #1;
        e = q.pop_front();
        checks++;
        if (value !== e.v) begin
            errs++;
            $display("FAIL saw_accept: got %h want %h", value, e.v);
        end
        cif.cfg_valid = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 32; k++) begin
            q.push_back('{v: 16'((k % 16) << 12) ^ 16'h8000,
                          w: (k % 16) == 15});
            @(posedge clk); #1;
            e = q.pop_front();
            checks++;
            if (value !== e.v) begin
                errs++;
                $display("FAIL saw_value[%0d]: got %h want %h", k, value, e.v);
            end
            checks++;
            if (wrap !== e.w) begin
                errs++;
                $display("FAIL saw_wrap[%0d]: got %b want %b", k, wrap, e.w);
            end
        end
    endtask

    // Sync accept while running, then check a 4-sample repeating pattern.
    task automatic sync_run(input string name, input logic [31:0] ph,
                            input logic [1:0] m, input logic [15:0] d,
                            input logic [15:0] first,
                            input logic [15:0] p0, input logic [15:0] p1,
                            input logic [15:0] p2, input logic [15:0] p3);
        logic [15:0] pat[4];
        pat[0] = p0; pat[1] = p1; pat[2] = p2; pat[3] = p3;
        offer(32'h4000_0000, ph, m, d, 1'b1);
        q.push_back('{v: first, w: 1'b0});
        @(posedge clk); #1;
        e = q.pop_front();
        checks++;
        if (value !== e.v) begin
            errs++;
            $display("FAIL %s_accept: got %h want %h", name, value, e.v);
        end
        cif.cfg_valid = 1'b0;
        cif.cfg_sync  = 1'b0;
        checks++;
        if (cif.cfg_ready !== 1'b1) begin
            errs++;
            $display("FAIL %s_sync_ready: got %b want 1", name, cif.cfg_ready);
        end
        for (int k = 0; k < 8; k++) begin
            q.push_back('{v: pat[k % 4], w: (k % 4) == 3});
            @(posedge clk); #1;
            e = q.pop_front();
            checks++;
            if (value !== e.v) begin
                errs++;
                $display("FAIL %s_value[%0d]: got %h want %h",
                         name, k, value, e.v);
            end
            checks++;
            if (wrap !== e.w) begin
                errs++;
                $display("FAIL %s_wrap[%0d]: got %b want %b",
                         name, k, wrap, e.w);
            end
        end
    endtask

    task automatic test_triangle;
        sync_run("tri", 32'h0, 2'd1, 16'h8000, 16'h8000,
                 16'h8000, 16'h0000, 16'h7FFF, 16'hFFFF);
    endtask

    task automatic test_pulse;
        sync_run("pulse", 32'h0, 2'd2, 16'h4000, 16'h8000,
                 16'h7FFF, 16'h8001, 16'h8001, 16'h8001);
        sync_run("pulse_ph", 32'h4000_0000, 2'd2, 16'h4000, 16'h7FFF,
                 16'h8001, 16'h8001, 16'h8001, 16'h7FFF);
    endtask

    task automatic test_sawdown;
        sync_run("sawdn", 32'h0, 2'd3, 16'h8000, 16'h8001,
                 16'h7FFF, 16'h3FFF, 16'hFFFF, 16'hBFFF);
    endtask

    task automatic test_pending;
        logic [31:0] m_acc;
        logic [31:0] m_freq;
        logic [31:0] nxt;
        logic        c;
        logic        pend;
        offer(32'h1000_0000, 32'h0, 2'd0, 16'h8000, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (value !== 16'h7FFF) begin
            errs++;
            $display("FAIL pend_sync: got %h want 7FFF", value);
        end
        cif.cfg_valid = 1'b0;
        cif.cfg_sync  = 1'b0;
        m_acc  = 32'h0;
        m_freq = 32'h1000_0000;
        pend   = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k == 3) begin
                offer(32'h2000_0000, 32'h0, 2'd0, 16'h8000, 1'b0);
                checks++;
                if (cif.cfg_ready !== 1'b1) begin
                    errs++;
                    $display("FAIL pend_offer_ready: got %b want 1",
                             cif.cfg_ready);
                end
            end
            {c, nxt} = {1'b0, m_acc} + {1'b0, m_freq};
            q.push_back('{v: m_acc[31:16] ^ 16'h8000, w: c});
            @(posedge clk); #1;
            if (pend && c) begin
                m_freq = 32'h2000_0000;
                pend   = 1'b0;
            end
            if (k == 3) begin
                pend = 1'b1;
                cif.cfg_valid = 1'b0;
            end
            m_acc = nxt;
            e = q.pop_front();
            checks++;
            if (value !== e.v) begin
                errs++;
                $display("FAIL pend_value[%0d]: got %h want %h", k, value, e.v);
            end
            checks++;
            if (wrap !== e.w) begin
                errs++;
                $display("FAIL pend_wrap[%0d]: got %b want %b", k, wrap, e.w);
            end
            checks++;
            if (cif.cfg_ready !== !pend) begin
                errs++;
                $display("FAIL pend_ready[%0d]: got %b want %b",
                         k, cif.cfg_ready, !pend);
            end
        end
    endtask

    task automatic test_pending_en0;
        logic [15:0] pat[4];
        pat[0] = 16'h8000; pat[1] = 16'hC000;
        pat[2] = 16'h0000; pat[3] = 16'h4000;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        en  = 1'b1;
        offer(32'h4000_0000, 32'h0, 2'd0, 16'h8000, 1'b0);
        @(posedge clk); #1;
        cif.cfg_valid = 1'b0;
        checks++;
        if (cif.cfg_ready !== 1'b0) begin
            errs++;
            $display("FAIL en0_pending: got %b want 0", cif.cfg_ready);
        end
        en = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (cif.cfg_ready !== 1'b1) begin
            errs++;
            $display("FAIL en0_released: got %b want 1", cif.cfg_ready);
        end
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            q.push_back('{v: pat[k], w: k == 3});
            @(posedge clk); #1;
            e = q.pop_front();
            checks++;
            if (value !== e.v) begin
                errs++;
                $display("FAIL en0_value[%0d]: got %h want %h", k, value, e.v);
            end
            checks++;
            if (wrap !== e.w) begin
                errs++;
                $display("FAIL en0_wrap[%0d]: got %b want %b", k, wrap, e.w);
            end
        end
    endtask

    task automatic test_pending_reset;
        offer(32'h2000_0000, 32'h0, 2'd1, 16'h8000, 1'b0);
        @(posedge clk); #1;
        cif.cfg_valid = 1'b0;
        checks++;
        if (cif.cfg_ready !== 1'b0) begin
            errs++;
            $display("FAIL prst_pending: got %b want 0", cif.cfg_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (value !== 16'h0000 || wrap !== 1'b0) begin
            errs++;
            $display("FAIL prst_outputs: got %h/%b want 0000/0", value, wrap);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cif.cfg_ready !== 1'b1) begin
            errs++;
            $display("FAIL prst_ready: got %b want 1", cif.cfg_ready);
        end
        for (int k = 0; k < 6; k++) begin
            q.push_back('{v: 16'h8000, w: 1'b0});
            @(posedge clk); #1;
            e = q.pop_front();
            checks++;
            if (value !== e.v || wrap !== e.w) begin
                errs++;
                $display("FAIL prst_hold[%0d]: got %h/%b want %h/%b",
                         k, value, wrap, e.v, e.w);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        cif.cfg_valid = 1'b0;
        cif.cfg_freq  = '0;
        cif.cfg_phase = '0;
        cif.cfg_mode  = '0;
        cif.cfg_duty  = '0;
        cif.cfg_sync  = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_saw();
        test_triangle();
        test_pulse();
        test_sawdown();
        test_pending();
        test_pending_en0();
        test_pending_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
